// File: rtl/cci_rd_arb_pkg.sv
// rtl/cci_rd_arb_pkg.sv - shared types and helpers for the channel-0 read arbiter
// Purpose: counter type, tag-width helper and mdata tag builder used by
// cci_rd_arbiter and rr_arbiter. No ports.
package cci_rd_arb_pkg;

    localparam int CCI_MDATA_W = 16;

    typedef logic [7:0] t_cci_rd_arb_cnt;

    // Width of the requester index carried in mdata; never below one bit.
    function automatic int rd_arb_id_w(input int n);
        return (n > 2) ? $clog2(n) : 1;
    endfunction

    // mdata tag: requester index in the low id_w bits, everything else zero.
    function automatic logic [CCI_MDATA_W-1:0] rd_arb_tag(input int unsigned id,
                                                          input int unsigned id_w);
        return CCI_MDATA_W'(id & ((32'd1 << id_w) - 32'd1));
    endfunction

endpackage

// File: rtl/cci_rd_arbiter_if.sv
// rtl/cci_rd_arbiter_if.sv - requester, channel-0 and response bundle for the read arbiter
// Purpose: groups the requester handshake, channel-0 TX/RX and response
// signals. Modport master is the arbiter's view, slave is the environment's
// (requesters plus MPF) view.
interface cci_rd_arbiter_if #(
    parameter int N_REQ   = 4,
    parameter int ADDR_W  = 42,
    parameter int DATA_W  = 512,
    parameter int MDATA_W = 16
);
    logic [N_REQ-1:0]        req_valid;
    logic [N_REQ*ADDR_W-1:0] req_addr;
    logic [N_REQ-1:0]        req_ready;
    logic                    c0_almfull;
    logic                    c0_tx_valid;
    logic [ADDR_W-1:0]       c0_tx_addr;
    logic [MDATA_W-1:0]      c0_tx_mdata;
    logic                    c0_rx_rdvalid;
    logic [MDATA_W-1:0]      c0_rx_mdata;
    logic [DATA_W-1:0]       c0_rx_data;
    logic [N_REQ-1:0]        rsp_valid;
    logic [DATA_W-1:0]       rsp_data;

    modport master (
        input  req_valid, req_addr, c0_almfull, c0_rx_rdvalid, c0_rx_mdata, c0_rx_data,
        output req_ready, c0_tx_valid, c0_tx_addr, c0_tx_mdata, rsp_valid, rsp_data
    );

    modport slave (
        output req_valid, req_addr, c0_almfull, c0_rx_rdvalid, c0_rx_mdata, c0_rx_data,
        input  req_ready, c0_tx_valid, c0_tx_addr, c0_tx_mdata, rsp_valid, rsp_data
    );
endinterface

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - round-robin arbiter with internal last-grant pointer
// Purpose: grants the first requesting index strictly after the last grant.
// Ports: clk, reset (async, active high), request[N], enable,
//        grant[N] (one-hot, combinational), grant_idx (valid when grant != 0).
module rr_arbiter
    import cci_rd_arb_pkg::*;
#(
    parameter  int N     = 4,
    localparam int IDX_W = rd_arb_id_w(N)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [N-1:0]     request,
    input  logic             enable,
    output logic [N-1:0]     grant,
    output logic [IDX_W-1:0] grant_idx
);

    logic [IDX_W-1:0] last_grant;

    // Scan N candidates starting just after last_grant; first hit wins.
    always_comb begin
        grant     = '0;
        grant_idx = last_grant;
        for (int k = 1; k <= N; k++) begin
            if (enable && (grant == '0) && request[(int'(last_grant) + k) % N]) begin
                grant[(int'(last_grant) + k) % N] = 1'b1;
                grant_idx = IDX_W'((int'(last_grant) + k) % N);
            end
        end
    end

    // Resetting to N-1 gives requester 0 first priority.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            last_grant <= IDX_W'(N - 1);
        end else if (grant != '0) begin
            last_grant <= grant_idx;
        end
    end

endmodule

// File: rtl/cci_rd_arbiter.sv
// rtl/cci_rd_arbiter.sv - shares the channel-0 read port among N_REQ requesters
// Purpose: round-robin grant gated by almost-full and per-requester
// outstanding limit, mdata tagging, and tag-based response routing.
// Ports: clk, reset (async, active high), bus (cci_rd_arbiter_if.master),
//        idle, err_bad_tag, err_underflow (sticky until reset).
module cci_rd_arbiter
    import cci_rd_arb_pkg::*;
#(
    parameter int N_REQ           = 4,
    parameter int MAX_OUTSTANDING = 64,
    parameter int ADDR_W          = 42,
    parameter int DATA_W          = 512,
    parameter int MDATA_W         = 16
) (
    input  logic                    clk,
    input  logic                    reset,
    cci_rd_arbiter_if.master        bus,
    output logic                    idle,
    output logic                    err_bad_tag,
    output logic                    err_underflow
);

    localparam int              ID_W    = rd_arb_id_w(N_REQ);
    localparam t_cci_rd_arb_cnt CNT_MAX = t_cci_rd_arb_cnt'(MAX_OUTSTANDING);

    logic [N_REQ-1:0]  elig;
    logic [N_REQ-1:0]  grant;
    logic [ID_W-1:0]   grant_idx;
    logic [ADDR_W-1:0] grant_addr;
    logic [N_REQ-1:0]  rsp_hit;
    logic [ID_W-1:0]   rx_id;
    logic              rx_in_range;
    logic              rx_underflow;
    logic              all_zero;
    t_cci_rd_arb_cnt   cnt      [N_REQ];
    t_cci_rd_arb_cnt   cnt_next [N_REQ];

    always_comb begin
        for (int i = 0; i < N_REQ; i++) begin
            elig[i] = bus.req_valid[i] && (cnt[i] < CNT_MAX);
        end
    end

    // Reset also holds off grants so req_ready reads 0 while reset is high.
    rr_arbiter #(.N(N_REQ)) u_rr (
        .clk       (clk),
        .reset     (reset),
        .request   (elig),
        .enable    (!bus.c0_almfull && !reset),
        .grant     (grant),
        .grant_idx (grant_idx)
    );

    assign bus.req_ready = grant;

    always_comb begin
        grant_addr = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (grant[i]) grant_addr = bus.req_addr[i*ADDR_W +: ADDR_W];
        end
    end

    // Response decode; ids outside 0..N_REQ-1 match no requester.
    assign rx_id       = bus.c0_rx_mdata[ID_W-1:0];
    assign rx_in_range = int'(rx_id) < N_REQ;

    always_comb begin
        rsp_hit      = '0;
        rx_underflow = 1'b0;
        for (int i = 0; i < N_REQ; i++) begin
            if (bus.c0_rx_rdvalid && (rx_id == ID_W'(i))) begin
                rsp_hit[i]   = 1'b1;
                rx_underflow = (cnt[i] == '0);
            end
        end
    end

    // A response to an empty counter is delivered but never decrements.
    always_comb begin
        all_zero = 1'b1;
        for (int i = 0; i < N_REQ; i++) begin
            cnt_next[i] = cnt[i];
            if (grant[i] && !(rsp_hit[i] && cnt[i] != '0)) begin
                cnt_next[i] = cnt[i] + 1'b1;
            end else if (!grant[i] && rsp_hit[i] && cnt[i] != '0) begin
                cnt_next[i] = cnt[i] - 1'b1;
            end
            if (cnt_next[i] != '0) all_zero = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bus.c0_tx_valid <= 1'b0;
            bus.c0_tx_addr  <= '0;
            bus.c0_tx_mdata <= '0;
            bus.rsp_valid   <= '0;
            bus.rsp_data    <= '0;
            for (int i = 0; i < N_REQ; i++) cnt[i] <= '0;
            idle            <= 1'b1;
            err_bad_tag     <= 1'b0;
            err_underflow   <= 1'b0;
        end else begin
            bus.c0_tx_valid <= |grant;
            if (|grant) begin
                bus.c0_tx_addr  <= grant_addr;
                bus.c0_tx_mdata <= MDATA_W'(rd_arb_tag(int'(grant_idx), ID_W));
            end
            bus.rsp_valid <= rsp_hit;
            if (bus.c0_rx_rdvalid) bus.rsp_data <= bus.c0_rx_data;
            for (int i = 0; i < N_REQ; i++) cnt[i] <= cnt_next[i];
            idle <= all_zero;
            if (bus.c0_rx_rdvalid && !rx_in_range) err_bad_tag <= 1'b1;
            if ((rsp_hit != '0) && rx_underflow)   err_underflow <= 1'b1;
        end
    end

endmodule

// File: tb/tb_cci_rd_arbiter.sv
// tb/tb_cci_rd_arbiter.sv - self-checking bench for cci_rd_arbiter
module tb_cci_rd_arbiter;

    localparam int N_REQ   = 3;
    localparam int MAX_OUT = 3;
    localparam int ADDR_W  = 42;
    localparam int DATA_W  = 64;
    localparam int MDATA_W = 16;

    logic clk = 1'b0;
    logic reset;
    logic idle, err_bad_tag, err_underflow;

    cci_rd_arbiter_if #(.N_REQ(N_REQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .MDATA_W(MDATA_W)) bus ();

    cci_rd_arbiter #(
        .N_REQ(N_REQ), .MAX_OUTSTANDING(MAX_OUT), .ADDR_W(ADDR_W),
        .DATA_W(DATA_W), .MDATA_W(MDATA_W)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .bus           (bus),
        .idle          (idle),
        .err_bad_tag   (err_bad_tag),
        .err_underflow (err_underflow)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    int                 cnt_m [N_REQ];
    int                 last_m;
    bit                 bad_m, und_m;
    bit                 exp_tx_valid;
    logic [ADDR_W-1:0]  exp_addr;
    logic [MDATA_W-1:0] exp_mdata;
    logic [N_REQ-1:0]   exp_rsp_valid;
    logic [DATA_W-1:0]  exp_rsp_data;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < N_REQ; i++) cnt_m[i] = 0;
        last_m        = N_REQ - 1;
        bad_m         = 0;
        und_m         = 0;
        exp_tx_valid  = 0;
        exp_addr      = '0;
        exp_mdata     = '0;
        exp_rsp_valid = '0;
        exp_rsp_data  = '0;
    endtask

    function automatic bit model_idle();
        for (int i = 0; i < N_REQ; i++) if (cnt_m[i] != 0) return 0;
        return 1;
    endfunction

    task automatic check_regs();
        chk("c0_tx_valid", 64'(bus.c0_tx_valid), 64'(exp_tx_valid));
        if (exp_tx_valid) begin
            chk("c0_tx_addr", 64'(bus.c0_tx_addr), 64'(exp_addr));
            chk("c0_tx_mdata", 64'(bus.c0_tx_mdata), 64'(exp_mdata));
        end
        chk("rsp_valid", 64'(bus.rsp_valid), 64'(exp_rsp_valid));
        if (exp_rsp_valid != '0) chk("rsp_data", 64'(bus.rsp_data), 64'(exp_rsp_data));
        chk("idle", 64'(idle), 64'(model_idle()));
        chk("err_bad_tag", 64'(err_bad_tag), 64'(bad_m));
        chk("err_underflow", 64'(err_underflow), 64'(und_m));
    endtask

    // One clock: drive at negedge, check req_ready, advance model at posedge,
    // check registered outputs at the following negedge.
    task automatic cycle(input logic [N_REQ-1:0] v, input bit af, input bit rv,
                         input logic [MDATA_W-1:0] md);
        int g;
        int id;
        logic [N_REQ-1:0]  exp_ready;
        logic [DATA_W-1:0] d;
        bus.req_valid = v;
        for (int i = 0; i < N_REQ; i++)
            bus.req_addr[i*ADDR_W +: ADDR_W] = ADDR_W'({$urandom, $urandom});
        d                 = {$urandom, $urandom};
        bus.c0_almfull    = af;
        bus.c0_rx_rdvalid = rv;
        bus.c0_rx_mdata   = md;
        bus.c0_rx_data    = d;
        #1;
        g = -1;
        if (!af) begin
            for (int k = 1; k <= N_REQ; k++) begin
                int j;
                j = (last_m + k) % N_REQ;
                if (g < 0 && v[j] && cnt_m[j] < MAX_OUT) g = j;
            end
        end
        exp_ready = (g >= 0) ? N_REQ'(1 << g) : '0;
        chk("req_ready", 64'(bus.req_ready), 64'(exp_ready));
        @(posedge clk);
        exp_rsp_valid = '0;
        if (rv) begin
            id = int'(md[1:0]);
            if (id >= N_REQ) begin
                bad_m = 1;
            end else begin
                exp_rsp_valid = N_REQ'(1 << id);
                exp_rsp_data  = d;
                if (cnt_m[id] == 0) und_m = 1;
                else cnt_m[id]--;
            end
        end
        if (g >= 0) begin
            exp_tx_valid = 1;
            exp_addr     = bus.req_addr[g*ADDR_W +: ADDR_W];
            exp_mdata    = MDATA_W'(g);
            cnt_m[g]++;
            last_m = g;
        end else begin
            exp_tx_valid = 0;
        end
        @(negedge clk);
        check_regs();
    endtask

    task automatic drain();
        for (int n = 0; n < 40; n++) begin
            int id;
            id = -1;
            for (int i = 0; i < N_REQ; i++) if (id < 0 && cnt_m[i] > 0) id = i;
            if (id < 0) break;
            cycle('0, 0, 1, MDATA_W'(id));
        end
    endtask

    task automatic check_reset_values(input string tag);
        chk({tag, "_req_ready"}, 64'(bus.req_ready), 64'(0));
        chk({tag, "_tx_valid"}, 64'(bus.c0_tx_valid), 64'(0));
        chk({tag, "_tx_addr"}, 64'(bus.c0_tx_addr), 64'(0));
        chk({tag, "_tx_mdata"}, 64'(bus.c0_tx_mdata), 64'(0));
        chk({tag, "_rsp_valid"}, 64'(bus.rsp_valid), 64'(0));
        chk({tag, "_rsp_data"}, 64'(bus.rsp_data), 64'(0));
        chk({tag, "_idle"}, 64'(idle), 64'(1));
        chk({tag, "_bad_tag"}, 64'(err_bad_tag), 64'(0));
        chk({tag, "_underflow"}, 64'(err_underflow), 64'(0));
    endtask

    initial begin
        bus.req_valid     = '0;
        bus.req_addr      = '0;
        bus.c0_almfull    = 1'b0;
        bus.c0_rx_rdvalid = 1'b0;
        bus.c0_rx_mdata   = '0;
        bus.c0_rx_data    = '0;
        reset             = 1'b1;
        model_reset();
        bus.req_valid     = '1;
        repeat (2) @(negedge clk);
        check_reset_values("rst");
        bus.req_valid = '0;
        reset = 1'b0;

        // Single requester 2, three back-to-back requests, then responses.
        for (int n = 0; n < 3; n++) cycle(3'b100, 0, 0, '0);
        chk("cnt2_busy", 64'(idle), 64'(0));
        for (int n = 0; n < 3; n++) cycle('0, 0, 1, 16'd2);
        chk("idle_back", 64'(idle), 64'(1));

        // Fairness and outstanding limit: all valid, no responses.
        for (int n = 0; n < 8; n++) cycle(3'b111, 0, 0, '0);
        cycle(3'b111, 0, 1, 16'd1);
        cycle(3'b111, 0, 0, '0);
        cycle(3'b111, 0, 0, '0);
        drain();

        // Almost-full blocks grants, resumes as soon as it drops.
        for (int n = 0; n < 5; n++) cycle(3'b111, 1, 0, '0);
        cycle(3'b111, 0, 0, '0);
        cycle(3'b111, 0, 0, '0);
        drain();

        // Grant and response to requester 0 in the same cycle.
        cycle(3'b001, 0, 0, '0);
        cycle(3'b001, 0, 1, 16'd0);
        drain();

        // Randomized traffic; responses only target in-flight requests.
        for (int n = 0; n < 400; n++) begin
            int pend [$];
            bit rv;
            logic [MDATA_W-1:0] md;
            pend.delete();
            for (int i = 0; i < N_REQ; i++) if (cnt_m[i] > 0) pend.push_back(i);
            rv = 0;
            md = '0;
            if (pend.size() > 0 && $urandom_range(0, 2) != 0) begin
                rv = 1;
                md = MDATA_W'(pend[$urandom_range(0, pend.size() - 1)]);
            end
            cycle(N_REQ'($urandom), ($urandom_range(0, 7) == 0), rv, md);
        end
        drain();

        // Error flags: underflow on empty counter, then out-of-range tag.
        cycle('0, 0, 1, 16'd0);
        cycle('0, 0, 1, 16'd3);
        cycle('0, 0, 0, '0);

        // Asynchronous reset mid-burst.
        cycle(3'b111, 0, 0, '0);
        cycle(3'b111, 0, 1, 16'd0);
        bus.req_valid = 3'b111;
        #2;
        reset = 1'b1;
        #1;
        model_reset();
        check_reset_values("async");
        @(negedge clk);
        reset = 1'b0;
        for (int n = 0; n < 4; n++) cycle(3'b011, 0, 0, '0);
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
